// File: rtl/imm_ext_pipe_pkg.sv
// Shared immediate-format encodings and FIFO state type for the decode pipeline.
package imm_ext_pipe_pkg;

  localparam int unsigned INS_W = 25;

  typedef enum logic [2:0] {
    ITYPE = 3'd0,
    STYPE = 3'd1,
    BTYPE = 3'd2,
    UTYPE = 3'd3,
    JTYPE = 3'd4,
    ZTYPE = 3'd5,
    RTYPE = 3'd6,
    NTYPE = 3'd7
  } imm_type_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/imm_ext_pipe_decode.sv
// imm_decode: combinational RISC-V immediate extraction and extension from
// instruction bits [31:7]; reusable by any pipeline stage.
module imm_decode
  import imm_ext_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [INS_W-1:0] INS,
  input  logic [2:0]       TYPE,
  output logic [XLEN-1:0]  IMM
);

  logic [31:7]        ins;
  logic signed [31:0] imm32;

  assign ins = INS;

  always_comb begin
    imm32 = '0;
    case (TYPE)
      ITYPE:   imm32 = {{20{ins[31]}}, ins[31:20]};
      STYPE:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      BTYPE:   imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      UTYPE:   imm32 = {ins[31:12], 12'b0};
      JTYPE:   imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      ZTYPE:   imm32 = {27'b0, ins[19:15]};
      default: imm32 = '0;
    endcase
  end

  // imm32 is signed, so widening to 64 replicates bit 31 (ZTYPE has it clear).
  assign IMM = XLEN'(imm32);

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage: decodes the immediate on entry and buffers
// finished results in a 2-deep valid/ready FIFO with registered IN_READY.
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [INS_W-1:0] INS,
  input  logic [2:0]       TYPE,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  IMM,
  output logic [2:0]       OUT_TYPE,
  output logic [TAG_W-1:0] OUT_TAG
);

  fifo_state_e      state_q, state_d;
  logic             in_ready_q;
  logic             push, pop;
  logic             load_head_in, load_head_tail, load_tail;
  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  head_imm, tail_imm;
  logic [2:0]       head_type, tail_type;
  logic [TAG_W-1:0] head_tag, tail_tag;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .INS  (INS),
    .TYPE (TYPE),
    .IMM  (dec_imm)
  );

  assign push      = IN_VALID && in_ready_q;
  assign pop       = OUT_VALID && OUT_READY;
  assign OUT_VALID = (state_q != EMPTY);
  assign IN_READY  = in_ready_q;
  assign IMM       = head_imm;
  assign OUT_TYPE  = head_type;
  assign OUT_TAG   = head_tag;

  // Head slot drives the outputs directly; tail only fills when head is busy.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    if (FLUSH) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d      = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_head_in = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            load_tail = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            load_head_tail = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head_imm  <= '0;
      head_type <= NTYPE;
      head_tag  <= '0;
    end else if (load_head_in) begin
      head_imm  <= dec_imm;
      head_type <= TYPE;
      head_tag  <= IN_TAG;
    end else if (load_head_tail) begin
      head_imm  <= tail_imm;
      head_type <= tail_type;
      head_tag  <= tail_tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (load_tail) begin
      tail_imm  <= dec_imm;
      tail_type <= TYPE;
      tail_tag  <= IN_TAG;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed immediate table, handshake corner cases,
// and randomized traffic scored against a queue-based reference model.
module tb_imm_ext_pipe;

  logic        CLK;
  logic        RST_N;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [24:0] INS;
  logic [2:0]  TYPE;
  logic [5:0]  IN_TAG;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] IMM;
  logic [2:0]  OUT_TYPE;
  logic [5:0]  OUT_TAG;

  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [2:0]  out_type32;
  logic [5:0]  out_tag32;

  imm_ext_pipe #(.XLEN(64), .TAG_W(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INS(INS), .TYPE(TYPE), .IN_TAG(IN_TAG), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .IMM(IMM), .OUT_TYPE(OUT_TYPE), .OUT_TAG(OUT_TAG)
  );

  imm_ext_pipe #(.XLEN(32), .TAG_W(6)) dut32 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(in_ready32),
    .INS(INS), .TYPE(TYPE), .IN_TAG(IN_TAG), .OUT_VALID(out_valid32), .OUT_READY(OUT_READY),
    .IMM(imm32), .OUT_TYPE(out_type32), .OUT_TAG(out_tag32)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input longint x, input int n);
    longint m;
    m = (longint'(1) << n) - 1;
    x = x & m;
    if (((x >> (n - 1)) & 1) != 0) x = x - (longint'(1) << n);
    return x;
  endfunction

  // Reference immediate from the full 32-bit instruction word.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] t);
    longint v;
    v = 0;
    case (t)
      3'd0: v = sext(longint'(w >> 20), 12);
      3'd1: v = sext(longint'(((w >> 25) << 5) | ((w >> 7) & 31)), 12);
      3'd2: v = sext(longint'((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                              (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1)), 13);
      3'd3: v = sext(longint'(w & 32'hFFFF_F000), 32);
      3'd4: v = sext(longint'((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                              (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1)), 21);
      3'd5: v = longint'((w >> 15) & 31);
      default: v = 0;
    endcase
    return v;
  endfunction

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [5:0]  tag;
  } ent_t;

  ent_t       q[$];
  logic [5:0] seen[$];
  logic [31:0] cur_word;
  bit         mon_en = 1'b0;

  // Reference model: a 2-entry FIFO of finished immediates, advanced each cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      int unsigned n;
      n = q.size();
      chk("mon_out_valid", {63'b0, OUT_VALID}, {63'b0, n != 0});
      chk("mon_in_ready", {63'b0, IN_READY}, {63'b0, n < 2});
      if (n != 0) begin
        chk("mon_imm", IMM, q[0].imm);
        chk("mon_type", {61'b0, OUT_TYPE}, {61'b0, q[0].typ});
        chk("mon_tag", {58'b0, OUT_TAG}, {58'b0, q[0].tag});
      end
      if (!RST_N || FLUSH) begin
        q.delete();
      end else begin
        if (n != 0 && OUT_READY) begin
          seen.push_back(q[0].tag);
          void'(q.pop_front());
        end
        if (IN_VALID && n < 2) begin
          ent_t e;
          e.imm = ref_imm(cur_word, TYPE);
          e.typ = TYPE;
          e.tag = IN_TAG;
          q.push_back(e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] t, input logic [5:0] tag);
    IN_VALID = v;
    cur_word = w;
    INS      = w[31:7];
    TYPE     = t;
    IN_TAG   = tag;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [2:0]  typ;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'hFFF0_0093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1]  = '{32'h1234_5037, 3'd3, 64'h0000_0000_1234_5000};
    vecs[2]  = '{32'h8000_00B7, 3'd3, 64'hFFFF_FFFF_8000_0000};
    vecs[3]  = '{32'h0080_006F, 3'd4, 64'h0000_0000_0000_0008};
    vecs[4]  = '{32'h800F_8073, 3'd5, 64'h0000_0000_0000_001F};
    vecs[5]  = '{32'hFE11_2E23, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[6]  = '{32'hFE00_0EE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[7]  = '{32'h7FF0_0093, 3'd0, 64'h0000_0000_0000_07FF};
    vecs[8]  = '{32'hFFFF_FFFF, 3'd6, 64'h0};
    vecs[9]  = '{32'hFFFF_FFFF, 3'd7, 64'h0};
    vecs[10] = '{32'h0000_0037, 3'd3, 64'h0};
    vecs[11] = '{32'h8000_006F, 3'd4, 64'hFFFF_FFFF_FFF0_0000};

    RST_N = 1'b0;
    FLUSH = 1'b0;
    OUT_READY = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 6'd0);
    step();
    step();
    chk("rst_out_valid", {63'b0, OUT_VALID}, 64'd0);
    chk("rst_in_ready", {63'b0, IN_READY}, 64'd1);
    chk("rst_imm", IMM, 64'd0);
    chk("rst_out_type", {61'b0, OUT_TYPE}, 64'd7);
    chk("rst_out_tag", {58'b0, OUT_TAG}, 64'd0);
    RST_N = 1'b1;
    mon_en = 1'b1;
    step();

    // Directed immediates, streamed back-to-back so each edge pushes and pops.
    OUT_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].word, vecs[i].typ, 6'(i + 1));
      step();
      chk("tbl_valid", {63'b0, OUT_VALID}, 64'd1);
      chk("tbl_imm", IMM, vecs[i].exp);
      chk("tbl_imm32", {32'b0, imm32}, {32'b0, vecs[i].exp[31:0]});
      chk("tbl_tag", {58'b0, OUT_TAG}, 64'(i + 1));
    end
    drive(1'b0, 32'h0, 3'd0, 6'd0);
    step();
    step();

    // Backpressure: three offers with OUT_READY low.
    seen.delete();
    OUT_READY = 1'b0;
    drive(1'b1, 32'h0010_0093, 3'd0, 6'd1);
    step();
    chk("bp_ready_one", {63'b0, IN_READY}, 64'd1);
    drive(1'b1, 32'h0020_0093, 3'd0, 6'd2);
    step();
    chk("bp_ready_full", {63'b0, IN_READY}, 64'd0);
    chk("bp_head_tag", {58'b0, OUT_TAG}, 64'd1);
    drive(1'b1, 32'h0030_0093, 3'd0, 6'd3);
    step();
    chk("bp_ready_hold", {63'b0, IN_READY}, 64'd0);
    chk("bp_imm_hold", IMM, 64'd1);
    OUT_READY = 1'b1;
    step();
    chk("bp_tag2", {58'b0, OUT_TAG}, 64'd2);
    chk("bp_ready_again", {63'b0, IN_READY}, 64'd1);
    step();
    drive(1'b0, 32'h0, 3'd0, 6'd0);
    chk("bp_tag3", {58'b0, OUT_TAG}, 64'd3);
    for (int i = 0; i < 4; i++) step();
    chk("bp_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("bp_order", {58'b0, seen[i]}, 64'(i + 1));
    end

    // Flush from FULL with a concurrent input, then from ONE with a push.
    seen.delete();
    OUT_READY = 1'b0;
    drive(1'b1, 32'h00A0_0093, 3'd0, 6'd10);
    step();
    drive(1'b1, 32'h00B0_0093, 3'd0, 6'd11);
    step();
    drive(1'b1, 32'h00C0_0093, 3'd0, 6'd12);
    FLUSH = 1'b1;
    step();
    chk("fl_full_valid", {63'b0, OUT_VALID}, 64'd0);
    chk("fl_full_ready", {63'b0, IN_READY}, 64'd1);
    FLUSH = 1'b0;
    drive(1'b1, 32'h00D0_0093, 3'd0, 6'd13);
    step();
    drive(1'b1, 32'h00E0_0093, 3'd0, 6'd14);
    FLUSH = 1'b1;
    step();
    chk("fl_one_valid", {63'b0, OUT_VALID}, 64'd0);
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 6'd0);
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("fl_nothing_out", 64'(seen.size()), 64'd0);

    // One-cycle reset while holding an entry.
    OUT_READY = 1'b0;
    drive(1'b1, 32'h0140_0093, 3'd0, 6'd20);
    step();
    drive(1'b1, 32'h0160_0093, 3'd0, 6'd22);
    RST_N = 1'b0;
    step();
    chk("mid_rst_valid", {63'b0, OUT_VALID}, 64'd0);
    chk("mid_rst_ready", {63'b0, IN_READY}, 64'd1);
    chk("mid_rst_imm", IMM, 64'd0);
    chk("mid_rst_type", {61'b0, OUT_TYPE}, 64'd7);
    chk("mid_rst_tag", {58'b0, OUT_TAG}, 64'd0);
    RST_N = 1'b1;
    drive(1'b1, 32'h0150_0093, 3'd0, 6'd21);
    step();
    chk("post_rst_valid", {63'b0, OUT_VALID}, 64'd1);
    chk("post_rst_tag", {58'b0, OUT_TAG}, 64'd21);
    chk("post_rst_imm", IMM, 64'h15);
    drive(1'b0, 32'h0, 3'd0, 6'd0);
    OUT_READY = 1'b1;
    step();
    step();

    // Randomized traffic; the monitor scores every cycle.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)), 6'($urandom));
      OUT_READY = ($urandom_range(0, 9) < 6);
      FLUSH = ($urandom_range(0, 39) == 0);
      step();
    end
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 6'd0);
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drain_empty", {63'b0, OUT_VALID}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
